// File: rtl/cell_fetch_pkg.sv
// cell_fetch_pkg: fetch FSM state encodings and the cell geometry defaults shared with the cell cache and the cell buffer
package cell_fetch_pkg;
  localparam int CELL_WIDTH_DEF = 768;
  localparam int CELL_NUM_DEF = 1200;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
endpackage

// File: rtl/cell_fetch_fifo.sv
// cell_fetch_fifo: 2-entry FIFO with registered head (ports clk, rst async, flush, push/din, pop, dout = head, cnt = occupancy)
module cell_fetch_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   cnt
);
  logic [W-1:0] e1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dout <= '0;
      e1 <= '0;
      cnt <= '0;
    end else if (flush) begin
      dout <= '0;
      cnt <= '0;
    end else begin
      dout <= pop ? ((push && cnt == 2'd1) ? din : e1) : ((push && cnt == 2'd0) ? din : dout);
      e1 <= (push && (pop ? cnt == 2'd2 : cnt == 2'd1)) ? din : e1;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
endmodule

// File: rtl/cell_fetch.sv
// cell_fetch: streams cells 0..CELL_NUM-1 from the cache read port to a valid/ready consumer (ports clk, rst async, start_i, busy_o, done_o, cell_rd_*, cell_data_o/idx_o/valid_o, cell_ready_i; optional abort_i under CELL_FETCH_ABORT_EN)
module cell_fetch import cell_fetch_pkg::*; #(
  parameter int CELL_WIDTH = CELL_WIDTH_DEF,
  parameter int CELL_NUM = CELL_NUM_DEF,
  localparam int CELL_ADDR_W = $clog2(CELL_NUM)
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef CELL_FETCH_ABORT_EN
  input  logic                   abort_i,
`endif
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   cell_rd_en_o,
  output logic [CELL_ADDR_W-1:0] cell_rd_addr_o,
  input  logic [CELL_WIDTH-1:0]  cell_rd_data_i,
  output logic [CELL_WIDTH-1:0]  cell_data_o,
  output logic [CELL_ADDR_W-1:0] cell_idx_o,
  output logic                   cell_valid_o,
  input  logic                   cell_ready_i
);
  localparam logic [CELL_ADDR_W-1:0] LAST = CELL_ADDR_W'(CELL_NUM - 1);
  state_t state_q, state_d;
  logic abort_in, abort, accept, pop, issue, last_pop, inflight_q;
  logic [CELL_ADDR_W-1:0] addr_q, inflight_idx_q;
  logic [1:0] cnt;
`ifdef CELL_FETCH_ABORT_EN
  assign abort_in = abort_i;
`else
  assign abort_in = 1'b0;
`endif
  assign busy_o = state_q != IDLE;
  assign abort = abort_in & busy_o;
  assign accept = (state_q == IDLE) & start_i & ~abort_in;
  assign pop = cell_valid_o & cell_ready_i;
  assign last_pop = pop & (cell_idx_o == LAST);
  assign issue = (state_q == FETCH) & ~abort & ({1'b0, cnt} + {2'b0, inflight_q} < 3'd2 + {2'b0, pop});
  assign cell_rd_en_o = issue;
  assign cell_rd_addr_o = addr_q;
  assign cell_valid_o = |cnt;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? FETCH : IDLE;
      FETCH:   state_d = (issue && addr_q == LAST) ? DRAIN : FETCH;
      DRAIN:   state_d = last_pop ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
    state_d = abort ? IDLE : state_d;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      inflight_q <= 1'b0;
      inflight_idx_q <= '0;
      done_o <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= accept ? '0 : (issue && addr_q != LAST) ? addr_q + CELL_ADDR_W'(1) : addr_q;
      inflight_q <= issue;
      inflight_idx_q <= addr_q;
      done_o <= (state_q == DRAIN) & last_pop & ~abort;
    end
  cell_fetch_fifo #(.W(CELL_WIDTH + CELL_ADDR_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(abort),
    .push(inflight_q),
    .pop(pop),
    .din({inflight_idx_q, cell_rd_data_i}),
    .dout({cell_idx_o, cell_data_o}),
    .cnt(cnt)
  );
endmodule

// File: tb/tb_cell_fetch.sv
// tb_cell_fetch: directed table-driven and sequence checks of cell_fetch with CELL_NUM=4, CELL_WIDTH=32
module tb_cell_fetch;
  typedef struct {
    int s, r, busy, en, addr, valid, idx, done;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, start_i = 1'b0, cell_ready_i = 1'b0, abort_i = 1'b0;
  logic busy_o, done_o, cell_rd_en_o, cell_valid_o;
  logic [1:0] cell_rd_addr_o, cell_idx_o;
  logic [31:0] cell_rd_data_i = '0, cell_data_o;
  int checks = 0, errors = 0, done_total = 0, base;
  logic [33:0] hs[$];
  vec_t tab[$];
  cell_fetch #(.CELL_WIDTH(32), .CELL_NUM(4)) dut (
    .clk(clk),
    .rst(rst),
`ifdef CELL_FETCH_ABORT_EN
    .abort_i(abort_i),
`endif
    .start_i(start_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .cell_rd_en_o(cell_rd_en_o),
    .cell_rd_addr_o(cell_rd_addr_o),
    .cell_rd_data_i(cell_rd_data_i),
    .cell_data_o(cell_data_o),
    .cell_idx_o(cell_idx_o),
    .cell_valid_o(cell_valid_o),
    .cell_ready_i(cell_ready_i)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (cell_rd_en_o) cell_rd_data_i <= 32'hA0 + 32'(cell_rd_addr_o);
  always @(posedge clk) begin
    if (cell_valid_o && cell_ready_i) hs.push_back({cell_idx_o, cell_data_o});
    if (done_o) done_total <= done_total + 1;
  end
  function automatic vec_t v(int s, int r, int busy, int en, int addr, int valid, int idx, int done);
    vec_t t;
    t.s = s; t.r = r; t.busy = busy; t.en = en; t.addr = addr; t.valid = valid; t.idx = idx; t.done = done;
    return t;
  endfunction
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_hs(input string n, input int frames);
    chk({n, "_count"}, 64'(hs.size()), 64'(4 * frames));
    for (int i = 0; i < hs.size() && i < 4 * frames; i++)
      chk($sformatf("%s_cell%0d", n, i), 64'(hs[i]), 64'({2'(i % 4), 32'hA0 + 32'(i % 4)}));
    hs.delete();
  endtask
  task automatic wait_done(input string n);
    int k;
    k = 0;
    while (!done_o && k < 40) begin
      tick;
      k++;
    end
    chk({n, "_done_seen"}, 64'(done_o), 64'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tab.push_back(v(1,1,0,0,0,0,0,0));
    tab.push_back(v(0,1,1,1,0,0,0,0));
    tab.push_back(v(0,1,1,1,1,0,0,0));
    tab.push_back(v(0,1,1,1,2,1,0,0));
    tab.push_back(v(0,1,1,1,3,1,1,0));
    tab.push_back(v(0,1,1,0,3,1,2,0));
    tab.push_back(v(0,1,1,0,3,1,3,0));
    tab.push_back(v(0,1,0,0,3,0,0,1));
    tab.push_back(v(0,1,0,0,3,0,0,0));
    tab.push_back(v(1,1,0,0,3,0,0,0));
    tab.push_back(v(0,1,1,1,0,0,0,0));
    tab.push_back(v(0,1,1,1,1,0,0,0));
    tab.push_back(v(0,0,1,0,2,1,0,0));
    tab.push_back(v(0,0,1,0,2,1,0,0));
    tab.push_back(v(1,0,1,0,2,1,0,0));
    for (int i = 0; i < 5; i++) tab.push_back(v(0,0,1,0,2,1,0,0));
    tab.push_back(v(0,1,1,1,2,1,0,0));
    tab.push_back(v(0,1,1,1,3,1,1,0));
    tab.push_back(v(0,1,1,0,3,1,2,0));
    tab.push_back(v(0,1,1,0,3,1,3,0));
    tab.push_back(v(0,1,0,0,3,0,0,1));
    tab.push_back(v(0,1,0,0,3,0,0,0));
    tab.push_back(v(1,1,0,0,3,0,0,0));
    tab.push_back(v(0,0,1,1,0,0,0,0));
    tab.push_back(v(0,1,1,1,1,0,0,0));
    tab.push_back(v(0,0,1,0,2,1,0,0));
    tab.push_back(v(0,1,1,1,2,1,0,0));
    tab.push_back(v(0,0,1,0,3,1,1,0));
    tab.push_back(v(0,1,1,1,3,1,1,0));
    tab.push_back(v(0,0,1,0,3,1,2,0));
    tab.push_back(v(0,1,1,0,3,1,2,0));
    tab.push_back(v(0,0,1,0,3,1,3,0));
    tab.push_back(v(0,1,1,0,3,1,3,0));
    tab.push_back(v(0,0,0,0,3,0,0,1));
    tab.push_back(v(0,1,0,0,3,0,0,0));
    #1;
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_valid", 64'(cell_valid_o), 0);
    chk("rst_en", 64'(cell_rd_en_o), 0);
    chk("rst_done", 64'(done_o), 0);
    repeat (3) tick;
    rst = 1'b0;
    repeat (6) tick;
    hs.delete();
    base = done_total;
    foreach (tab[i]) begin
      start_i = 1'(tab[i].s);
      cell_ready_i = 1'(tab[i].r);
      #1;
      chk($sformatf("row%0d_busy", i), 64'(busy_o), 64'(tab[i].busy));
      chk($sformatf("row%0d_en", i), 64'(cell_rd_en_o), 64'(tab[i].en));
      chk($sformatf("row%0d_addr", i), 64'(cell_rd_addr_o), 64'(tab[i].addr));
      chk($sformatf("row%0d_valid", i), 64'(cell_valid_o), 64'(tab[i].valid));
      chk($sformatf("row%0d_done", i), 64'(done_o), 64'(tab[i].done));
      if (tab[i].valid != 0) begin
        chk($sformatf("row%0d_idx", i), 64'(cell_idx_o), 64'(tab[i].idx));
        chk($sformatf("row%0d_data", i), 64'(cell_data_o), 64'(32'hA0 + tab[i].idx));
      end
      tick;
    end
    start_i = 1'b0;
    cell_ready_i = 1'b1;
    tick;
    chk("tab_dones", 64'(done_total - base), 3);
    chk_hs("tab", 3);
    base = done_total;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    tick;
    tick;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    wait_done("busy_start");
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    chk("b2b_busy", 64'(busy_o), 1);
    wait_done("b2b");
    tick;
    chk("b2b_dones", 64'(done_total - base), 2);
    chk_hs("b2b", 2);
    base = done_total;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    tick;
    tick;
    chk("pre_rst_valid", 64'(cell_valid_o), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy_o), 0);
    chk("mid_rst_valid", 64'(cell_valid_o), 0);
    chk("mid_rst_en", 64'(cell_rd_en_o), 0);
    chk("mid_rst_addr", 64'(cell_rd_addr_o), 0);
    chk("mid_rst_idx", 64'(cell_idx_o), 0);
    chk("mid_rst_data", 64'(cell_data_o), 0);
    tick;
    rst = 1'b0;
    repeat (6) tick;
    chk("mid_rst_dones", 64'(done_total - base), 0);
    chk_hs("mid_rst", 0);
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    wait_done("post_rst");
    tick;
    chk("post_rst_dones", 64'(done_total - base), 1);
    chk_hs("post_rst", 1);
`ifdef CELL_FETCH_ABORT_EN
    base = done_total;
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    repeat (3) tick;
    abort_i = 1'b1;
    tick;
    abort_i = 1'b0;
    chk("abort_busy", 64'(busy_o), 0);
    chk("abort_valid", 64'(cell_valid_o), 0);
    repeat (6) tick;
    chk("abort_dones", 64'(done_total - base), 0);
    chk("abort_valid_late", 64'(cell_valid_o), 0);
    hs.delete();
    start_i = 1'b1;
    tick;
    start_i = 1'b0;
    wait_done("post_abort");
    tick;
    chk("post_abort_dones", 64'(done_total - base), 1);
    chk_hs("post_abort", 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
